pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Stall/flush sequencer for the 5-stage MIPS pipeline. Detects load-use hazards (ID vs EX),
//  taken branches resolved in MEM, jumps decoded in ID, and data-memory wait states. Drives
//  PC/IF-ID/ID-EX/EX-MEM write enables, flushes, and the main Control decoder enable (bubble).
//  Keeps saturating stall/flush counters for performance measurement.
// PARAMETERS
//  LU_STALLS  1   bubbles inserted per load-use hazard (1..7)
//  WAIT_MAX   15  MEM_WAIT cycles before mem_timeout sets (1..255)
//  CNT_W      16  width of stall_cycles / flush_count
// PORTS
//  clk              in   1      clock, rising edge
//  reset_n          in   1      asynchronous reset, active low
//  id_opcode        in   6      opcode of instruction in ID
//  id_rs            in   5      rs field in ID
//  id_rt            in   5      rt field in ID
//  ex_memread       in   1      instruction in EX is LW
//  ex_rt            in   5      destination rt of instruction in EX
//  branch_taken_mem in   1      BEQ in MEM resolved taken
//  jump_id          in   1      J decoded in ID
//  mem_access       in   1      LW/SW in MEM stage
//  dmem_ready       in   1      data memory completes access this cycle
//  pc_write         out  1      PC load enable
//  ifid_write       out  1      IF/ID load enable
//  ifid_flush       out  1      IF/ID -> NOP
//  ctrl_enable      out  1      Control decoder enable; 0 = bubble into ID/EX
//  idex_write       out  1      ID/EX load enable
//  exmem_write      out  1      EX/MEM load enable
//  exmem_flush      out  1      EX/MEM control bits cleared
//  memwb_bubble     out  1      MEM/WB RegWrite/MemtoReg forced 0
//  mem_timeout      out  1      sticky: a MEM_WAIT reached WAIT_MAX
//  stall_cycles     out  CNT_W  cycles with pc_write=0 (saturating)
//  flush_count      out  CNT_W  branch+jump flush events (saturating)
// BEHAVIOUR
//  Reset (reset_n=0, async): state=RUN, lu_cnt=0, wait_cnt=0, mem_timeout=0, counters=0;
//   all outputs 0 while reset_n=0. Outputs are Mealy (comb. of state + inputs), no latency.
//  Default (no event): pc_write=ifid_write=idex_write=exmem_write=ctrl_enable=1, flushes=0.
//  uses_rt = id_opcode in {000000,101011,000100}. lu_hazard = ex_memread & ex_rt!=0 &
//   (ex_rt==id_rs | (uses_rt & ex_rt==id_rt)). mem_stall = mem_access & !dmem_ready.
//  Priority per cycle, any state: mem_stall > branch_taken_mem > lu/LU_STALL > jump_id.
//  RUN: mem_stall -> freeze (all write enables 0, memwb_bubble=1), go MEM_WAIT, wait_cnt=1.
//   branch -> ifid_flush=1, ctrl_enable=0, exmem_flush=1, pc_write=1; stay RUN.
//   lu_hazard -> pc_write=0, ifid_write=0, ctrl_enable=0; if LU_STALLS>1 lu_cnt=LU_STALLS-1,
//   go LU_STALL. jump_id -> ifid_flush=1, pc_write=1.
//  LU_STALL: same outputs as lu bubble; lu_cnt-1 each cycle; lu_cnt==1 -> RUN next.
//   Branch here: branch flush, lu_cnt=0, -> RUN. mem_stall: freeze, lu_cnt held, -> MEM_WAIT.
//  MEM_WAIT: freeze; wait_cnt +1 (saturates 255); wait_cnt==WAIT_MAX sets mem_timeout (no exit).
//   dmem_ready -> release this cycle (defaults/branch/lu rules apply), wait_cnt=0,
//   next = LU_STALL if lu_cnt!=0 else RUN. Branch held while frozen, served after release.
//  stall_cycles +1 every cycle pc_write=0; flush_count +1 on branch or jump flush; saturate.
//  mem_timeout cleared only by reset.
// TESTING
//  1 LW $2 in EX, ADD rs=$2 in ID, LU_STALLS=1 -> one cycle pc_write=0,ctrl_enable=0; stall_cycles=1.
//  2 LW ex_rt=0, id_rs=0 -> no stall (r0 exempt); LW ex_rt=5, LW id_rt=5 -> no stall (rt not source).
//  3 branch_taken_mem=1 with lu_hazard=1 -> ifid_flush=exmem_flush=1, ctrl_enable=0, pc_write=1.
//  4 mem_access=1, dmem_ready=0 for 3 cycles -> all writes 0, memwb_bubble=1, then release; stall=3.
//  5 WAIT_MAX=4, dmem_ready low 6 cycles -> mem_timeout=1 at 4th wait cycle, stays 1 after release.
//  6 LU_STALLS=3, mem_stall in 2nd bubble -> 3 bubbles total, freeze in between; reset_n low mid-op -> all 0, RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles, branch/jump
// flushes, data-memory wait freezes, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int LU_STALLS = 1,
  parameter int WAIT_MAX  = 15,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken_mem,
  input  logic             jump_id,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             ctrl_enable,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] LU_RELOAD  = 3'(LU_STALLS - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  state_t           r_state;
  logic [2:0]       r_luCnt;
  logic [7:0]       r_waitCnt;
  logic             r_memTimeout;
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushCount;

  state_t     w_next;
  logic [2:0] w_luNext;
  logic [7:0] w_waitNext;
  logic       w_usesRt;
  logic       w_luHazard;
  logic       w_memStall;
  logic       w_flushEvt;
  logic       w_pcWrite;
  logic       w_ifidWrite;
  logic       w_ifidFlush;
  logic       w_ctrlEnable;
  logic       w_idexWrite;
  logic       w_exmemWrite;
  logic       w_exmemFlush;
  logic       w_memwbBubble;

  assign w_usesRt   = (id_opcode == 6'b000000) || (id_opcode == 6'b101011) ||
                      (id_opcode == 6'b000100);
  assign w_luHazard = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (w_usesRt && (ex_rt == id_rt)));
  assign w_memStall = mem_access && !dmem_ready;

  // Priority: memory freeze, then taken branch, then owed/new load-use bubble, then jump.
  always_comb begin
    w_pcWrite     = 1'b1;
    w_ifidWrite   = 1'b1;
    w_ifidFlush   = 1'b0;
    w_ctrlEnable  = 1'b1;
    w_idexWrite   = 1'b1;
    w_exmemWrite  = 1'b1;
    w_exmemFlush  = 1'b0;
    w_memwbBubble = 1'b0;
    w_flushEvt    = 1'b0;
    w_next        = r_state;
    w_luNext      = r_luCnt;
    w_waitNext    = r_waitCnt;
    if (w_memStall) begin
      w_pcWrite     = 1'b0;
      w_ifidWrite   = 1'b0;
      w_idexWrite   = 1'b0;
      w_exmemWrite  = 1'b0;
      w_memwbBubble = 1'b1;
      w_next        = MEM_WAIT;
      if (r_state == MEM_WAIT)
        w_waitNext = (r_waitCnt == 8'd255) ? 8'd255 : r_waitCnt + 8'd1;
      else
        w_waitNext = 8'd1;
    end else begin
      w_waitNext = 8'd0;
      if (branch_taken_mem) begin
        w_ifidFlush  = 1'b1;
        w_ctrlEnable = 1'b0;
        w_exmemFlush = 1'b1;
        w_flushEvt   = 1'b1;
        w_luNext     = 3'd0;
        w_next       = RUN;
      end else if (r_state == LU_STALL) begin
        w_pcWrite    = 1'b0;
        w_ifidWrite  = 1'b0;
        w_ctrlEnable = 1'b0;
        w_luNext     = r_luCnt - 3'd1;
        w_next       = (r_luCnt == 3'd1) ? RUN : LU_STALL;
      end else begin
        // RUN, or the release cycle out of MEM_WAIT resuming any owed bubbles.
        w_next = (r_luCnt != 3'd0) ? LU_STALL : RUN;
        if (w_luHazard) begin
          w_pcWrite    = 1'b0;
          w_ifidWrite  = 1'b0;
          w_ctrlEnable = 1'b0;
          if ((r_luCnt == 3'd0) && (LU_STALLS > 1)) begin
            w_luNext = LU_RELOAD;
            w_next   = LU_STALL;
          end
        end else if (jump_id) begin
          w_ifidFlush = 1'b1;
          w_flushEvt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RUN;
      r_luCnt       <= 3'd0;
      r_waitCnt     <= 8'd0;
      r_memTimeout  <= 1'b0;
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      r_state   <= w_next;
      r_luCnt   <= w_luNext;
      r_waitCnt <= w_waitNext;
      if (w_memStall && (w_waitNext == WAIT_LIMIT))
        r_memTimeout <= 1'b1;
      if (!w_pcWrite && (r_stallCycles != {CNT_W{1'b1}}))
        r_stallCycles <= r_stallCycles + CNT_W'(1);
      if (w_flushEvt && (r_flushCount != {CNT_W{1'b1}}))
        r_flushCount <= r_flushCount + CNT_W'(1);
    end
  end

  // Every combinational output is held low while reset is asserted.
  assign pc_write     = reset_n & w_pcWrite;
  assign ifid_write   = reset_n & w_ifidWrite;
  assign ifid_flush   = reset_n & w_ifidFlush;
  assign ctrl_enable  = reset_n & w_ctrlEnable;
  assign idex_write   = reset_n & w_idexWrite;
  assign exmem_write  = reset_n & w_exmemWrite;
  assign exmem_flush  = reset_n & w_exmemFlush;
  assign memwb_bubble = reset_n & w_memwbBubble;
  assign mem_timeout  = r_memTimeout;
  assign stall_cycles = r_stallCycles;
  assign flush_count  = r_flushCount;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two parameterisations driven in lockstep, directed
// scenarios then random traffic, each compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, branch_taken_mem, jump_id, mem_access, dmem_ready;

  logic pcW[2], ifidW[2], ifidF[2], ctrlE[2], idexW[2], exmemW[2], exmemF[2], mwB[2], tmo[2];
  logic [15:0] stallA, flushA;
  logic [4:0]  stallB, flushB;

  pipeline_hazard_ctrl #(.LU_STALLS(1), .WAIT_MAX(15), .CNT_W(16)) dutA (
    .clk(clk), .reset_n(reset_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken_mem(branch_taken_mem),
    .jump_id(jump_id), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(pcW[0]), .ifid_write(ifidW[0]), .ifid_flush(ifidF[0]), .ctrl_enable(ctrlE[0]),
    .idex_write(idexW[0]), .exmem_write(exmemW[0]), .exmem_flush(exmemF[0]),
    .memwb_bubble(mwB[0]), .mem_timeout(tmo[0]), .stall_cycles(stallA), .flush_count(flushA));

  pipeline_hazard_ctrl #(.LU_STALLS(3), .WAIT_MAX(4), .CNT_W(5)) dutB (
    .clk(clk), .reset_n(reset_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken_mem(branch_taken_mem),
    .jump_id(jump_id), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(pcW[1]), .ifid_write(ifidW[1]), .ifid_flush(ifidF[1]), .ctrl_enable(ctrlE[1]),
    .idex_write(idexW[1]), .exmem_write(exmemW[1]), .exmem_flush(exmemF[1]),
    .memwb_bubble(mwB[1]), .mem_timeout(tmo[1]), .stall_cycles(stallB), .flush_count(flushB));

  // Output vector order: {pc, ifid_w, ifid_flush, ctrl_en, idex_w, exmem_w, exmem_flush, memwb_bubble}
  localparam logic [7:0] EXP_DEFAULT = 8'b1101_1100;
  localparam logic [7:0] EXP_FREEZE  = 8'b0001_0001;
  localparam logic [7:0] EXP_BRANCH  = 8'b1110_1110;
  localparam logic [7:0] EXP_BUBBLE  = 8'b0000_1100;
  localparam logic [7:0] EXP_JUMP    = 8'b1111_1100;

  int pLu[2]  = '{1, 3};
  int pWm[2]  = '{15, 4};
  int pMax[2] = '{65535, 31};

  bit mInWait[2];
  int mPend[2];
  int mWaitRun[2];
  bit mTimeout[2];
  int mStalls[2];
  int mFlushes[2];

  int checks = 0;
  int errors = 0;
  int stepNo = 0;

  task automatic checkOutput(input string tag, input int k, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s dut%0d step %0d observed=%0h expected=%0h", tag, k, stepNo, obs, exp);
    end
  endtask

  task automatic modelReset(input int k);
    mInWait[k]  = 1'b0;
    mPend[k]    = 0;
    mWaitRun[k] = 0;
    mTimeout[k] = 1'b0;
    mStalls[k]  = 0;
    mFlushes[k] = 0;
  endtask

  // One cycle of the reference behaviour: expected outputs now, state for the next cycle.
  task automatic modelStep(input int k, input bit memStall, input bit br, input bit lu,
                           input bit jp, output logic [7:0] e);
    bit owed;
    e = EXP_DEFAULT;
    if (memStall) begin
      e = EXP_FREEZE;
      mWaitRun[k] = mInWait[k] ? ((mWaitRun[k] >= 255) ? 255 : mWaitRun[k] + 1) : 1;
      if (mWaitRun[k] == pWm[k]) mTimeout[k] = 1'b1;
      mInWait[k] = 1'b1;
    end else begin
      owed = !mInWait[k] && (mPend[k] > 0);
      mInWait[k]  = 1'b0;
      mWaitRun[k] = 0;
      if (br) begin
        e = EXP_BRANCH;
        mPend[k] = 0;
      end else if (owed) begin
        e = EXP_BUBBLE;
        mPend[k] = mPend[k] - 1;
      end else if (lu) begin
        e = EXP_BUBBLE;
        if (mPend[k] == 0) mPend[k] = pLu[k] - 1;
      end else if (jp) begin
        e = EXP_JUMP;
      end
    end
    if (e[7] == 1'b0 && mStalls[k] < pMax[k]) mStalls[k]++;
    if (e[5] == 1'b1 && mFlushes[k] < pMax[k]) mFlushes[k]++;
  endtask

  function automatic logic [7:0] obsVec(input int k);
    return {pcW[k], ifidW[k], ifidF[k], ctrlE[k], idexW[k], exmemW[k], exmemF[k], mwB[k]};
  endfunction

  function automatic logic [31:0] obsStall(input int k);
    return (k == 0) ? 32'(stallA) : 32'(stallB);
  endfunction

  function automatic logic [31:0] obsFlush(input int k);
    return (k == 0) ? 32'(flushA) : 32'(flushB);
  endfunction

  // Drive one cycle of inputs (called just after a rising edge) and check mid-cycle.
  task automatic applyStimulus(input bit rst, input logic [5:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input bit exmr, input logic [4:0] exrt,
                               input bit br, input bit jp, input bit ma, input bit dr);
    bit lu;
    bit usesRt;
    logic [7:0] e;
    reset_n = !rst; id_opcode = op; id_rs = rs; id_rt = rt; ex_memread = exmr; ex_rt = exrt;
    branch_taken_mem = br; jump_id = jp; mem_access = ma; dmem_ready = dr;
    usesRt = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04);
    lu = exmr && (exrt != 5'd0) && ((exrt == rs) || (usesRt && (exrt == rt)));
    #4;
    stepNo++;
    for (int k = 0; k < 2; k++) begin
      if (rst) modelReset(k);
      checkOutput("mem_timeout", k, 32'(tmo[k]), 32'(mTimeout[k]));
      checkOutput("stall_cycles", k, obsStall(k), 32'(mStalls[k]));
      checkOutput("flush_count", k, obsFlush(k), 32'(mFlushes[k]));
      if (rst) e = 8'h00;
      else modelStep(k, ma && !dr, br, lu, jp, e);
      checkOutput("outputs", k, 32'(obsVec(k)), 32'(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 6'h08, 5'd1, 5'd1, 0, 5'd0, 0, 0, 0, 1);
  endtask

  initial begin
    reset_n = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0; ex_memread = 1'b0; ex_rt = '0;
    branch_taken_mem = 1'b0; jump_id = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
    for (int k = 0; k < 2; k++) modelReset(k);
    @(posedge clk);
    #1;
    applyStimulus(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
    applyStimulus(1, 6'h00, 5'd2, 5'd2, 1, 5'd2, 1, 1, 1, 0);

    // LW $2 in EX, ADD using $2 in ID
    applyStimulus(0, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 0, 0, 1);
    idle(4);

    // r0 exempt, and LW's rt is not a source
    applyStimulus(0, 6'h00, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 1);
    applyStimulus(0, 6'h23, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, 1);
    applyStimulus(0, 6'h2b, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, 1);
    idle(3);

    // Branch beats a simultaneous load-use hazard; then a plain jump
    applyStimulus(0, 6'h00, 5'd2, 5'd3, 1, 5'd2, 1, 0, 0, 1);
    applyStimulus(0, 6'h02, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 1);

    // Three-cycle memory wait, then release
    for (int i = 0; i < 3; i++) applyStimulus(0, 6'h08, 5'd1, 5'd1, 0, 5'd0, 0, 0, 1, 0);
    applyStimulus(0, 6'h08, 5'd1, 5'd1, 0, 5'd0, 0, 0, 1, 1);
    idle(1);

    // Six-cycle wait with a branch held: small-WAIT_MAX instance times out
    for (int i = 0; i < 6; i++) applyStimulus(0, 6'h08, 5'd1, 5'd1, 0, 5'd0, 1, 0, 1, 0);
    applyStimulus(0, 6'h08, 5'd1, 5'd1, 0, 5'd0, 1, 0, 1, 1);
    idle(2);

    // Load-use, memory stall in the second bubble, release, remaining bubbles
    applyStimulus(0, 6'h00, 5'd4, 5'd1, 1, 5'd4, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 6'h00, 5'd4, 5'd1, 0, 5'd0, 0, 0, 1, 0);
    applyStimulus(0, 6'h00, 5'd4, 5'd1, 0, 5'd0, 0, 0, 1, 1);
    idle(3);

    // Reset in the middle of a bubble sequence
    applyStimulus(0, 6'h2b, 5'd1, 5'd6, 1, 5'd6, 0, 0, 0, 1);
    applyStimulus(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0);
    idle(2);

    // Long wait so the default instance times out too; many jumps to saturate counters
    for (int i = 0; i < 16; i++) applyStimulus(0, 6'h08, 5'd1, 5'd1, 0, 5'd0, 0, 0, 1, 0);
    applyStimulus(0, 6'h08, 5'd1, 5'd1, 0, 5'd0, 0, 0, 1, 1);
    for (int i = 0; i < 36; i++) applyStimulus(0, 6'h02, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 1);
    idle(1);

    for (int i = 0; i < 500; i++) begin
      logic [5:0] op;
      int sel;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       op = 6'h00;
        1:       op = 6'h2b;
        2:       op = 6'h04;
        3:       op = 6'h23;
        default: op = 6'h08;
      endcase
      applyStimulus($urandom_range(0, 99) == 0, op,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
